// File: rtl/reg_write_arbiter_pkg.sv
// Shared writeback definitions: register-address/data widths and requester IDs
// used by the register file, the datapath and the writeback arbiter.
package reg_write_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } reqId_t;

    typedef struct packed {
        logic [REG_W-1:0]  regAddr;
        logic [DATA_W-1:0] data;
    } wbEntry_t;

    function automatic logic isZeroReg(input logic [REG_W-1:0] regAddr);
        return regAddr == '0;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_wb_slot.sv
// One-entry writeback buffer: holds a pending register write until the
// arbiter drains it. A load on the drain edge keeps the slot full.
module wb_slot
    import reg_write_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  logic     drain,
    input  wbEntry_t loadEntry,
    output logic     full,
    output wbEntry_t entry
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (load) begin
            full  <= 1'b1;
            entry <= loadEntry;
        end else if (drain) begin
            full  <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-requester register-file write arbiter: ALU (A) and load (B) writebacks
// each get a one-entry slot; one slot is written per cycle, ties round-robin.
//
// lastGrant | meaning
// ----------+-----------------------------------------------------
// REQ_A     | A won the last tie, B wins the next one
// REQ_B     | B won the last tie (reset value), A wins the next one
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter bit ZERO_REG_DROP = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              a_valid,
    input  logic [REG_W-1:0]  a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [REG_W-1:0]  b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [REG_W-1:0]  writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              RegWrite,
    output logic              busy
);

    logic     aFull, bFull;
    wbEntry_t aEntry, bEntry;
    logic     grantA, grantB, anyGrant;
    logic     aLoad, bLoad;
    logic     writeEnable;
    wbEntry_t grantEntry;
    reqId_t   lastGrant, lastGrantNext;

    // Ready is gated by reset so nothing is accepted while RST is held.
    assign a_ready = ~RST & (~aFull | grantA);
    assign b_ready = ~RST & (~bFull | grantB);
    assign aLoad   = a_valid & a_ready;
    assign bLoad   = b_valid & b_ready;
    assign busy    = aFull | bFull;

    wb_slot slotA (
        .clk       (CLK),
        .rst       (RST),
        .load      (aLoad),
        .drain     (grantA),
        .loadEntry ('{regAddr: a_reg, data: a_data}),
        .full      (aFull),
        .entry     (aEntry)
    );

    wb_slot slotB (
        .clk       (CLK),
        .rst       (RST),
        .load      (bLoad),
        .drain     (grantB),
        .loadEntry ('{regAddr: b_reg, data: b_data}),
        .full      (bFull),
        .entry     (bEntry)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lastGrant <= REQ_B;
        end else begin
            lastGrant <= lastGrantNext;
        end
    end

    // Pointer only moves on a contested grant; a lone requester never shifts priority.
    always_comb begin
        grantA        = 1'b0;
        grantB        = 1'b0;
        lastGrantNext = lastGrant;
        if (aFull && bFull) begin
            if (lastGrant == REQ_B) begin
                grantA        = 1'b1;
                lastGrantNext = REQ_A;
            end else begin
                grantB        = 1'b1;
                lastGrantNext = REQ_B;
            end
        end else begin
            grantA = aFull;
            grantB = bFull;
        end
    end

    assign anyGrant    = grantA | grantB;
    assign grantEntry  = grantA ? aEntry : bEntry;
    assign writeEnable = anyGrant &
                         ~(ZERO_REG_DROP & isZeroReg(grantEntry.regAddr));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RegWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            RegWrite <= writeEnable;
            if (anyGrant) begin
                writeReg  <= grantEntry.regAddr;
                writeData <= grantEntry.data;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural register file that
// writes on the falling edge and a log of every issued write.
module tb_reg_write_arbiter;

    logic        CLK;
    logic        RST;
    logic        a_valid, b_valid;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        RegWrite;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] tbRegFile [32];
    logic [36:0] wlog [$];

    reg_write_arbiter dut (
        .CLK       (CLK),
        .RST       (RST),
        .a_valid   (a_valid),
        .a_reg     (a_reg),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_reg     (b_reg),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .writeReg  (writeReg),
        .writeData (writeData),
        .RegWrite  (RegWrite),
        .busy      (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(negedge CLK) begin
        if (RegWrite === 1'b1) begin
            tbRegFile[writeReg] = writeData;
            wlog.push_back({writeReg, writeData});
        end
    end

    task automatic checkVal(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [36:0] expStream [9] = '{
        {5'd11, 32'hB00}, {5'd10, 32'hA00}, {5'd11, 32'hB01}, {5'd10, 32'hA01},
        {5'd11, 32'hB02}, {5'd10, 32'hA02}, {5'd11, 32'hB03}, {5'd10, 32'hA03},
        {5'd11, 32'hB04}
    };

    initial begin
        int aIdx, bIdx, logCnt;
        logic aAcc, bAcc;

        for (int i = 0; i < 32; i++) tbRegFile[i] = '0;
        RST = 1'b1;
        a_valid = 0; b_valid = 0;
        a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;

        #2;
        checkVal("rst_regwrite", RegWrite, 1'b0);
        checkVal("rst_writereg", writeReg, 5'd0);
        checkVal("rst_writedata", writeData, 32'd0);
        checkVal("rst_busy", busy, 1'b0);
        tick();
        tick();
        RST = 1'b0;
        #0;
        checkVal("idle_a_ready", a_ready, 1'b1);
        checkVal("idle_b_ready", b_ready, 1'b1);

        // single request from A
        a_valid = 1; a_reg = 5'd5; a_data = 32'h1234;
        tick();
        a_valid = 0;
        checkVal("single_busy", busy, 1'b1);
        checkVal("single_no_write_yet", RegWrite, 1'b0);
        tick();
        checkVal("single_regwrite", RegWrite, 1'b1);
        checkVal("single_writereg", writeReg, 5'd5);
        checkVal("single_writedata", writeData, 32'h1234);
        checkVal("single_busy_clear", busy, 1'b0);
        tick();
        checkVal("single_regwrite_low", RegWrite, 1'b0);
        checkVal("single_writereg_hold", writeReg, 5'd5);
        checkVal("single_rf5", tbRegFile[5], 32'h1234);

        // simultaneous requests: pointer resets to B, so A wins
        a_valid = 1; a_reg = 5'd3; a_data = 32'hA;
        b_valid = 1; b_reg = 5'd4; b_data = 32'hB;
        tick();
        a_valid = 0; b_valid = 0;
        checkVal("tie_b_ready_low", b_ready, 1'b0);
        checkVal("tie_a_ready_high", a_ready, 1'b1);
        tick();
        checkVal("tie_first_reg", writeReg, 5'd3);
        checkVal("tie_first_data", writeData, 32'hA);
        checkVal("tie_first_we", RegWrite, 1'b1);
        tick();
        checkVal("tie_second_reg", writeReg, 5'd4);
        checkVal("tie_second_data", writeData, 32'hB);
        checkVal("tie_second_we", RegWrite, 1'b1);
        tick();
        checkVal("tie_done_we", RegWrite, 1'b0);
        checkVal("tie_done_busy", busy, 1'b0);

        // continuous streaming; A won the last tie so B leads
        wlog.delete();
        aIdx = 0; bIdx = 0;
        for (int i = 0; i < 8; i++) begin
            a_valid = 1; a_reg = 5'd10; a_data = 32'hA00 + aIdx;
            b_valid = 1; b_reg = 5'd11; b_data = 32'hB00 + bIdx;
            #0;
            aAcc = a_ready;
            bAcc = b_ready;
            if (i > 0) checkVal($sformatf("stream_ready_alt%0d", i), a_ready ^ b_ready, 1'b1);
            tick();
            if (aAcc) aIdx++;
            if (bIdx >= 0 && bAcc) bIdx++;
        end
        a_valid = 0; b_valid = 0;
        tick();
        tick();
        tick();
        checkVal("stream_a_accepts", aIdx, 4);
        checkVal("stream_b_accepts", bIdx, 5);
        checkVal("stream_len", wlog.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < wlog.size()) checkVal($sformatf("stream_w%0d", i), wlog[i], expStream[i]);

        // write to register 0 drains without a register-file write
        wlog.delete();
        b_valid = 1; b_reg = 5'd0; b_data = 32'hFFFF;
        tick();
        b_valid = 0;
        checkVal("zero_busy", busy, 1'b1);
        tick();
        checkVal("zero_we", RegWrite, 1'b0);
        checkVal("zero_drained", busy, 1'b0);
        tick();
        checkVal("zero_no_log", wlog.size(), 0);
        checkVal("zero_rf0", tbRegFile[0], 32'd0);

        // same register from both requesters in consecutive cycles
        wlog.delete();
        a_valid = 1; a_reg = 5'd7; a_data = 32'd1;
        tick();
        a_valid = 0;
        b_valid = 1; b_reg = 5'd7; b_data = 32'd2;
        tick();
        b_valid = 0;
        tick();
        tick();
        checkVal("same_len", wlog.size(), 2);
        if (wlog.size() == 2) begin
            checkVal("same_w0", wlog[0], {5'd7, 32'd1});
            checkVal("same_w1", wlog[1], {5'd7, 32'd2});
        end
        checkVal("same_rf7", tbRegFile[7], 32'd2);

        // reset mid-operation; pointer is A after the stream drain, so B goes first
        a_valid = 1; a_reg = 5'd12; a_data = 32'hC;
        b_valid = 1; b_reg = 5'd13; b_data = 32'hD;
        tick();
        a_valid = 0; b_valid = 0;
        checkVal("midrst_busy", busy, 1'b1);
        tick();
        checkVal("midrst_we_before", RegWrite, 1'b1);
        checkVal("midrst_reg_before", writeReg, 5'd13);
        #2;
        RST = 1'b1;
        #1;
        checkVal("midrst_we", RegWrite, 1'b0);
        checkVal("midrst_busy_clr", busy, 1'b0);
        checkVal("midrst_writereg", writeReg, 5'd0);
        checkVal("midrst_writedata", writeData, 32'd0);
        logCnt = wlog.size();
        tick();
        tick();
        RST = 1'b0;
        #0;
        checkVal("postrst_a_ready", a_ready, 1'b1);
        checkVal("postrst_b_ready", b_ready, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        checkVal("postrst_no_write", wlog.size(), logCnt);
        checkVal("postrst_rf12", tbRegFile[12], 32'd0);
        checkVal("postrst_rf13", tbRegFile[13], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
